tx_packet_scheduler: RTL and testbench
======================================

Name: tx_packet_scheduler

Overview:
- Sequences the single serial Sender datapath among four packet sources: ACK, game-lost, ready, data-update.
- Implements stop-and-wait reliability for non-ACK packets: 1-bit sequence number, ACK matching, timeout retransmit, bounded retries.
- Sits between SenderFSM/game logic (requesters), Receiver (ack_received/ack_seqNum) and Sender (start/done).
- Replaces ad-hoc OR-ing of send_ready and send_ready_ACK.

Parameters:
- TIMEOUT_CYCLES, 5000, clk cycles in WAIT_ACK before retransmit (≥2).
- MAX_RETRIES, 7, retransmits allowed before link_error (≥1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_ack  in  1  pulse: Receiver needs an ACK sent
- req_ack_seq  in  1  seqNum to echo in that ACK, sampled with req_ack
- req_lost  in  1  pulse: send game-lost packet
- req_ready  in  1  pulse: send ready packet
- req_data  in  1  pulse: send data-update packet
- ack_received  in  1  pulse from Receiver: ACK arrived
- ack_seqNum  in  1  seqNum carried by that ACK
- send_done  in  1  pulse from Sender: packet fully shifted out
- err_clear  in  1  pulse: clear link_error
- send_start  out  1  one-cycle pulse to Sender
- send_type  out  2  0=ACK, 1=READY, 2=LOST, 3=DATA; stable from send_start to send_done
- send_seqNum  out  1  seq field; stable from send_start to send_done
- busy  out  1  state != IDLE
- outstanding  out  1  reliable packet awaiting ACK
- retry_cnt  out  3  retransmits of current packet
- acked_cnt  out  4  reliable packets acknowledged, wraps 15→0 (HEX display)
- link_error  out  1  sticky: retries exhausted

Behaviour:
- Reset: state IDLE; all pending flags 0; tx_seq 0; timer 0.
- Reset outputs: send_start 0, send_type 0, send_seqNum 0, busy 0, outstanding 0, retry_cnt 0, acked_cnt 0, link_error 0.
- Reset mid-packet abandons it; no send_start until a new request arrives.
- Requests set sticky pending flags; repeated pulses before service coalesce into one packet.
- A new req_ack overwrites the stored ACK seq.
- States: IDLE, SEND, WAIT_ACK.
- IDLE, ACK pending: SEND with type ACK, seq = stored ACK seq. Clear ACK pending.
- IDLE, no ACK pending, no outstanding: pick LOST > READY > DATA, seq = tx_seq. Clear that flag; set outstanding.
- IDLE→SEND pulses send_start for exactly the first SEND cycle; type/seq are registered on that same edge.
- A request pulse arriving the cycle IDLE decides is honoured: the flag is set, and it is visible to arbitration the next cycle.
- SEND: wait for send_done. Then WAIT_ACK if outstanding, else IDLE. send_done in IDLE/WAIT_ACK is ignored.
- WAIT_ACK, ACK pending: SEND that ACK (interleave). Timer holds during the interleave and resumes after; outstanding is unaffected.
- WAIT_ACK: timer increments each cycle.
- Timeout, timer == TIMEOUT_CYCLES-1, retry_cnt < MAX_RETRIES: retry_cnt++, timer 0, resend the same type/seq (send_start pulse).
- Timeout, timer == TIMEOUT_CYCLES-1, retry_cnt == MAX_RETRIES: set link_error; clear outstanding, retry_cnt, and LOST/READY/DATA pending; go IDLE. ACK pending is kept.
- Matching ACK (ack_received && outstanding && ack_seqNum == tx_seq) is accepted in any state, including during an ACK interleave:
  - outstanding 0, tx_seq toggles, retry_cnt 0, timer 0, acked_cnt++.
  - If in WAIT_ACK, go IDLE next cycle.
- Matching ACK during SEND of that same reliable packet is still accepted; after send_done, go IDLE.
- Mismatched ACK, or any ACK with outstanding 0, is ignored.
- ACK acceptance and timeout on the same cycle: ACK wins, no retransmit.
- link_error is cleared only by err_clear or rst. Requests are still serviced while link_error=1.
- err_clear and a new error on the same cycle: link_error stays 1.

Test Plan (TIMEOUT_CYCLES=20, MAX_RETRIES=2):
- req_ready; send_done after 5 cycles; ack_received with seq 0 → one send_start, type 1, seq 0; outstanding 1→0; acked_cnt=1; tx_seq=1; busy 0.
- req_data, req_ready, req_lost on the same cycle → packets sent in order LOST, READY, DATA, each after its ACK, with seqs 0, 1, 0.
- req_data, then no ACK → retransmits 20 cycles after each send_done (retry_cnt 1, 2); the third timeout gives link_error=1, outstanding 0, no further send_start; err_clear → link_error 0.
- In WAIT_ACK after DATA seq 0, pulse req_ack with req_ack_seq=1 → ACK packet (type 0, seq 1) sent before any retransmit; timer paused; then ack_received seq 0 → acked_cnt++, IDLE.
- In WAIT_ACK with seq 1, ack_received seq 0 → ignored, retransmit at timeout. Then an ACK with seq 1 on the exact timeout cycle → accepted, no send_start.
- rst asserted mid-SEND → all outputs at reset values next cycle; a stray send_done afterwards causes no change.

Source files
------------

// File: rtl/tx_packet_scheduler.sv
// tx_packet_scheduler: arbitrates the single serial Sender among ACK, LOST,
// READY and DATA packets. Non-ACK packets use stop-and-wait with a 1-bit
// sequence number, timeout retransmit and a bounded retry count.
module tx_packet_scheduler #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int MAX_RETRIES    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_ack,
  input  logic       req_ack_seq,
  input  logic       req_lost,
  input  logic       req_ready,
  input  logic       req_data,
  input  logic       ack_received,
  input  logic       ack_seqNum,
  input  logic       send_done,
  input  logic       err_clear,
  output logic       send_start,
  output logic [1:0] send_type,
  output logic       send_seqNum,
  output logic       busy,
  output logic       outstanding,
  output logic [2:0] retry_cnt,
  output logic [3:0] acked_cnt,
  output logic       link_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    RETRY_MAX  = 3'(MAX_RETRIES);

  localparam logic [1:0] T_ACK   = 2'd0;
  localparam logic [1:0] T_READY = 2'd1;
  localparam logic [1:0] T_LOST  = 2'd2;
  localparam logic [1:0] T_DATA  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_ACK} state_t;

  state_t        state_q, state_d;
  logic          ack_pend_q, ack_pend_d;
  logic          ack_seq_q, ack_seq_d;
  logic          lost_pend_q, lost_pend_d;
  logic          ready_pend_q, ready_pend_d;
  logic          data_pend_q, data_pend_d;
  logic          tx_seq_q, tx_seq_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    retry_q, retry_d;
  logic [3:0]    acked_q, acked_d;
  logic          link_err_q, link_err_d;
  logic          outstanding_q, outstanding_d;
  logic          send_start_q, send_start_d;
  logic [1:0]    type_q, type_d;
  logic          seq_q, seq_d;
  logic [1:0]    rel_type_q, rel_type_d;  // type of the reliable packet awaiting ACK

  logic ack_match;
  logic clr_ack, clr_lost, clr_ready, clr_data, set_err;

  assign ack_match = ack_received && outstanding_q && (ack_seqNum == tx_seq_q);

  // Next-state logic: arbitration, stop-and-wait control and pending flags
  always_comb begin
    state_d       = state_q;
    send_start_d  = 1'b0;
    type_d        = type_q;
    seq_d         = seq_q;
    rel_type_d    = rel_type_q;
    outstanding_d = outstanding_q;
    tx_seq_d      = tx_seq_q;
    timer_d       = timer_q;
    retry_d       = retry_q;
    acked_d       = acked_q;
    clr_ack       = 1'b0;
    clr_lost      = 1'b0;
    clr_ready     = 1'b0;
    clr_data      = 1'b0;
    set_err       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ack_pend_q) begin
          state_d      = S_SEND;
          send_start_d = 1'b1;
          type_d       = T_ACK;
          seq_d        = ack_seq_q;
          clr_ack      = 1'b1;
        end else if (!outstanding_q && (lost_pend_q || ready_pend_q || data_pend_q)) begin
          state_d       = S_SEND;
          send_start_d  = 1'b1;
          seq_d         = tx_seq_q;
          outstanding_d = 1'b1;
          timer_d       = '0;
          retry_d       = '0;
          if (lost_pend_q) begin
            type_d   = T_LOST;
            clr_lost = 1'b1;
          end else if (ready_pend_q) begin
            type_d    = T_READY;
            clr_ready = 1'b1;
          end else begin
            type_d   = T_DATA;
            clr_data = 1'b1;
          end
          rel_type_d = type_d;
        end
      end
      S_SEND: begin
        // An ACK accepted during this packet means there is nothing to wait for
        if (send_done)
          state_d = (outstanding_q && !ack_match) ? S_WAIT_ACK : S_IDLE;
      end
      S_WAIT_ACK: begin
        if (ack_match) begin
          state_d = S_IDLE;
        end else if (ack_pend_q) begin
          // Interleave the ACK; timer holds until we return here
          state_d      = S_SEND;
          send_start_d = 1'b1;
          type_d       = T_ACK;
          seq_d        = ack_seq_q;
          clr_ack      = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          if (retry_q < RETRY_MAX) begin
            retry_d      = retry_q + 3'd1;
            state_d      = S_SEND;
            send_start_d = 1'b1;
            type_d       = rel_type_q;
            seq_d        = tx_seq_q;
          end else begin
            set_err       = 1'b1;
            outstanding_d = 1'b0;
            retry_d       = '0;
            clr_lost      = 1'b1;
            clr_ready     = 1'b1;
            clr_data      = 1'b1;
            state_d       = S_IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ack_match) begin
      outstanding_d = 1'b0;
      tx_seq_d      = ~tx_seq_q;
      retry_d       = '0;
      timer_d       = '0;
      acked_d       = acked_q + 4'd1;
    end
  end

  // Request flags are sticky; a pulse on the deciding cycle still registers
  assign ack_pend_d   = (ack_pend_q & ~clr_ack) | req_ack;
  assign ack_seq_d    = req_ack ? req_ack_seq : ack_seq_q;
  assign lost_pend_d  = (lost_pend_q & ~clr_lost) | req_lost;
  assign ready_pend_d = (ready_pend_q & ~clr_ready) | req_ready;
  assign data_pend_d  = (data_pend_q & ~clr_data) | req_data;
  assign link_err_d   = (link_err_q & ~err_clear) | set_err;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ack_pend_q    <= 1'b0;
      ack_seq_q     <= 1'b0;
      lost_pend_q   <= 1'b0;
      ready_pend_q  <= 1'b0;
      data_pend_q   <= 1'b0;
      tx_seq_q      <= 1'b0;
      timer_q       <= '0;
      retry_q       <= '0;
      acked_q       <= '0;
      link_err_q    <= 1'b0;
      outstanding_q <= 1'b0;
      send_start_q  <= 1'b0;
      type_q        <= T_ACK;
      seq_q         <= 1'b0;
      rel_type_q    <= T_ACK;
    end else begin
      state_q       <= state_d;
      ack_pend_q    <= ack_pend_d;
      ack_seq_q     <= ack_seq_d;
      lost_pend_q   <= lost_pend_d;
      ready_pend_q  <= ready_pend_d;
      data_pend_q   <= data_pend_d;
      tx_seq_q      <= tx_seq_d;
      timer_q       <= timer_d;
      retry_q       <= retry_d;
      acked_q       <= acked_d;
      link_err_q    <= link_err_d;
      outstanding_q <= outstanding_d;
      send_start_q  <= send_start_d;
      type_q        <= type_d;
      seq_q         <= seq_d;
      rel_type_q    <= rel_type_d;
    end
  end

  assign send_start  = send_start_q;
  assign send_type   = type_q;
  assign send_seqNum = seq_q;
  assign busy        = (state_q != S_IDLE);
  assign outstanding = outstanding_q;
  assign retry_cnt   = retry_q;
  assign acked_cnt   = acked_q;
  assign link_error  = link_err_q;

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Directed testbench for tx_packet_scheduler with TIMEOUT_CYCLES=20, MAX_RETRIES=2.
module tb_tx_packet_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_ack = 0, req_ack_seq = 0, req_lost = 0, req_ready = 0, req_data = 0;
  logic       ack_received = 0, ack_seqNum = 0, send_done = 0, err_clear = 0;
  logic       send_start, send_seqNum, busy, outstanding, link_error;
  logic [1:0] send_type;
  logic [2:0] retry_cnt;
  logic [3:0] acked_cnt;

  int checks = 0;
  int passes = 0;
  int start_count = 0;

  tx_packet_scheduler #(.TIMEOUT_CYCLES(20), .MAX_RETRIES(2)) dut (
    .clk(clk), .rst(rst),
    .req_ack(req_ack), .req_ack_seq(req_ack_seq),
    .req_lost(req_lost), .req_ready(req_ready), .req_data(req_data),
    .ack_received(ack_received), .ack_seqNum(ack_seqNum),
    .send_done(send_done), .err_clear(err_clear),
    .send_start(send_start), .send_type(send_type), .send_seqNum(send_seqNum),
    .busy(busy), .outstanding(outstanding), .retry_cnt(retry_cnt),
    .acked_cnt(acked_cnt), .link_error(link_error)
  );

  always #5 clk = ~clk;

  // Count send_start pulses mid-cycle
  always @(negedge clk) if (send_start === 1'b1) start_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    {req_ack, req_ack_seq, req_lost, req_ready, req_data} = '0;
    {ack_received, ack_seqNum, send_done, err_clear} = '0;
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  task automatic wait_start(input int maxc, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (!ok && n <= maxc) begin
      if (send_start === 1'b1) ok = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic pulse_done();
    send_done = 1'b1;
    tick();
    send_done = 1'b0;
  endtask

  task automatic pulse_ack(input logic s);
    ack_received = 1'b1;
    ack_seqNum = s;
    tick();
    ack_received = 1'b0;
    ack_seqNum = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (send_start !== 1'b0) $display("FAIL reset_send_start: got %0d expected 0", send_start); else passes++;
    checks++; if (send_type !== 2'd0) $display("FAIL reset_send_type: got %0d expected 0", send_type); else passes++;
    checks++; if (send_seqNum !== 1'b0) $display("FAIL reset_send_seq: got %0d expected 0", send_seqNum); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0d expected 0", busy); else passes++;
    checks++; if (outstanding !== 1'b0) $display("FAIL reset_outstanding: got %0d expected 0", outstanding); else passes++;
    checks++; if (retry_cnt !== 3'd0) $display("FAIL reset_retry: got %0d expected 0", retry_cnt); else passes++;
    checks++; if (acked_cnt !== 4'd0) $display("FAIL reset_acked: got %0d expected 0", acked_cnt); else passes++;
    checks++; if (link_error !== 1'b0) $display("FAIL reset_link_error: got %0d expected 0", link_error); else passes++;
    $display("test_reset: outputs checked after reset");
  endtask

  task automatic test_single();
    int n; bit ok; int s0;
    do_reset();
    s0 = start_count;
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    wait_start(10, n, ok);
    checks++; if (!ok) $display("FAIL single_start: got none expected send_start within 10"); else passes++;
    checks++; if (send_type !== 2'd1 || send_seqNum !== 1'b0) $display("FAIL single_pkt: got type %0d seq %0d expected 1 0", send_type, send_seqNum); else passes++;
    checks++; if (outstanding !== 1'b1 || busy !== 1'b1) $display("FAIL single_outstanding: got out %0d busy %0d expected 1 1", outstanding, busy); else passes++;
    tick();
    checks++; if (send_start !== 1'b0) $display("FAIL single_pulse_width: got %0d expected 0", send_start); else passes++;
    ticks(4);
    pulse_done();
    pulse_ack(1'b0);
    checks++; if (outstanding !== 1'b0 || busy !== 1'b0 || acked_cnt !== 4'd1) $display("FAIL single_acked: got out %0d busy %0d acked %0d expected 0 0 1", outstanding, busy, acked_cnt); else passes++;
    ticks(3);
    checks++; if (start_count - s0 !== 1) $display("FAIL single_start_count: got %0d expected 1", start_count - s0); else passes++;
    $display("test_single: ready packet sent and acknowledged");
  endtask

  task automatic test_priority();
    int n; bit ok; int snap;
    logic [1:0] exp_type [3];
    logic       exp_seq  [3];
    exp_type[0] = 2'd2; exp_type[1] = 2'd1; exp_type[2] = 2'd3;
    exp_seq[0]  = 1'b0; exp_seq[1]  = 1'b1; exp_seq[2]  = 1'b0;
    do_reset();
    req_data = 1'b1; req_ready = 1'b1; req_lost = 1'b1;
    tick();
    {req_data, req_ready, req_lost} = '0;
    for (int k = 0; k < 3; k++) begin
      wait_start(10, n, ok);
      checks++; if (!ok || send_type !== exp_type[k] || send_seqNum !== exp_seq[k])
        $display("FAIL prio_pkt%0d: got ok %0d type %0d seq %0d expected type %0d seq %0d", k, ok, send_type, send_seqNum, exp_type[k], exp_seq[k]);
      else passes++;
      ticks(2);
      pulse_done();
      snap = start_count;
      ticks(3);
      checks++; if (start_count !== snap) $display("FAIL prio_wait%0d: got %0d starts expected 0 before ACK", k, start_count - snap); else passes++;
      pulse_ack(exp_seq[k]);
    end
    checks++; if (acked_cnt !== 4'd3 || busy !== 1'b0) $display("FAIL prio_acked: got acked %0d busy %0d expected 3 0", acked_cnt, busy); else passes++;
    $display("test_priority: LOST, READY, DATA order checked");
  endtask

  task automatic test_retry();
    int n; bit ok; int snap;
    do_reset();
    req_data = 1'b1; tick(); req_data = 1'b0;
    wait_start(10, n, ok);
    checks++; if (!ok || send_type !== 2'd3) $display("FAIL retry_first: got ok %0d type %0d expected 1 3", ok, send_type); else passes++;
    for (int r = 1; r <= 2; r++) begin
      ticks(2);
      pulse_done();
      wait_start(40, n, ok);
      checks++; if (!ok || n !== 20) $display("FAIL retry_delay%0d: got %0d cycles expected 20", r, n); else passes++;
      checks++; if (retry_cnt !== 3'(r) || send_type !== 2'd3 || send_seqNum !== 1'b0)
        $display("FAIL retry_pkt%0d: got retry %0d type %0d seq %0d expected %0d 3 0", r, retry_cnt, send_type, send_seqNum, r);
      else passes++;
    end
    ticks(2);
    pulse_done();
    ticks(19);
    checks++; if (link_error !== 1'b0) $display("FAIL retry_err_early: got %0d expected 0", link_error); else passes++;
    tick();
    checks++; if (link_error !== 1'b1 || outstanding !== 1'b0 || retry_cnt !== 3'd0 || busy !== 1'b0)
      $display("FAIL retry_err: got err %0d out %0d retry %0d busy %0d expected 1 0 0 0", link_error, outstanding, retry_cnt, busy);
    else passes++;
    snap = start_count;
    ticks(30);
    checks++; if (start_count !== snap || link_error !== 1'b1) $display("FAIL retry_quiet: got %0d starts err %0d expected 0 1", start_count - snap, link_error); else passes++;
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    checks++; if (link_error !== 1'b0) $display("FAIL retry_err_clear: got %0d expected 0", link_error); else passes++;
    $display("test_retry: retransmits and link_error checked");
  endtask

  task automatic test_interleave();
    int n; bit ok; int snap;
    do_reset();
    req_data = 1'b1; tick(); req_data = 1'b0;
    wait_start(10, n, ok);
    ticks(2);
    pulse_done();
    ticks(5);
    req_ack = 1'b1; req_ack_seq = 1'b1; tick(); req_ack = 1'b0; req_ack_seq = 1'b0;
    wait_start(5, n, ok);
    checks++; if (!ok || send_type !== 2'd0 || send_seqNum !== 1'b1) $display("FAIL intl_ack_pkt: got ok %0d type %0d seq %0d expected 1 0 1", ok, send_type, send_seqNum); else passes++;
    checks++; if (outstanding !== 1'b1 || retry_cnt !== 3'd0) $display("FAIL intl_outstanding: got out %0d retry %0d expected 1 0", outstanding, retry_cnt); else passes++;
    ticks(3);
    pulse_done();
    snap = start_count;
    ticks(12);
    checks++; if (start_count !== snap || busy !== 1'b1) $display("FAIL intl_timer_hold: got %0d starts busy %0d expected 0 1", start_count - snap, busy); else passes++;
    pulse_ack(1'b0);
    checks++; if (acked_cnt !== 4'd1 || busy !== 1'b0 || outstanding !== 1'b0) $display("FAIL intl_acked: got acked %0d busy %0d out %0d expected 1 0 0", acked_cnt, busy, outstanding); else passes++;
    ticks(25);
    checks++; if (start_count !== snap) $display("FAIL intl_no_resend: got %0d starts expected 0", start_count - snap); else passes++;
    $display("test_interleave: ACK interleave during WAIT_ACK checked");
  endtask

  task automatic test_mismatch();
    int n; bit ok; int snap;
    do_reset();
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    wait_start(10, n, ok);
    ticks(2);
    pulse_done();
    pulse_ack(1'b0);
    req_data = 1'b1; tick(); req_data = 1'b0;
    wait_start(10, n, ok);
    checks++; if (!ok || send_type !== 2'd3 || send_seqNum !== 1'b1) $display("FAIL mis_pkt: got ok %0d type %0d seq %0d expected 1 3 1", ok, send_type, send_seqNum); else passes++;
    ticks(2);
    pulse_done();
    ticks(3);
    pulse_ack(1'b0);
    checks++; if (outstanding !== 1'b1 || acked_cnt !== 4'd1) $display("FAIL mis_ignored: got out %0d acked %0d expected 1 1", outstanding, acked_cnt); else passes++;
    wait_start(40, n, ok);
    checks++; if (!ok || n !== 16 || retry_cnt !== 3'd1 || send_seqNum !== 1'b1) $display("FAIL mis_resend: got ok %0d cycles %0d retry %0d seq %0d expected 1 16 1 1", ok, n, retry_cnt, send_seqNum); else passes++;
    ticks(2);
    pulse_done();
    ticks(19);
    snap = start_count;
    pulse_ack(1'b1);
    checks++; if (send_start !== 1'b0 || outstanding !== 1'b0 || acked_cnt !== 4'd2 || busy !== 1'b0 || retry_cnt !== 3'd0)
      $display("FAIL mis_ack_at_timeout: got start %0d out %0d acked %0d busy %0d retry %0d expected 0 0 2 0 0", send_start, outstanding, acked_cnt, busy, retry_cnt);
    else passes++;
    ticks(5);
    checks++; if (start_count !== snap) $display("FAIL mis_no_resend: got %0d starts expected 0", start_count - snap); else passes++;
    $display("test_mismatch: mismatched ACK and timeout race checked");
  endtask

  task automatic test_reset_mid();
    int n; bit ok; int snap;
    do_reset();
    req_lost = 1'b1; tick(); req_lost = 1'b0;
    wait_start(10, n, ok);
    ticks(2);
    rst = 1'b1; tick();
    checks++; if (send_start !== 1'b0 || send_type !== 2'd0 || send_seqNum !== 1'b0 || busy !== 1'b0 || outstanding !== 1'b0 || acked_cnt !== 4'd0)
      $display("FAIL midrst_outputs: got start %0d type %0d seq %0d busy %0d out %0d acked %0d expected all 0", send_start, send_type, send_seqNum, busy, outstanding, acked_cnt);
    else passes++;
    rst = 1'b0;
    snap = start_count;
    tick();
    pulse_done();
    ticks(5);
    checks++; if (start_count !== snap || busy !== 1'b0 || outstanding !== 1'b0) $display("FAIL midrst_stray_done: got starts %0d busy %0d out %0d expected 0 0 0", start_count - snap, busy, outstanding); else passes++;
    $display("test_reset_mid: reset during SEND checked");
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_retry();
    test_interleave();
    test_mismatch();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
